// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two write-back sources.
// Grants are combinational; the winning address/data/select/strobe are registered.
module wb_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Valid1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Data1,
    output logic              Ready1,
    input  logic              Valid2,
    input  logic [ADDR_W-1:0] Addr2,
    input  logic [DATA_W-1:0] Data2,
    output logic              Ready2,
    input  logic              Hold,
    output logic              choose,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  ConflictCnt
);

    logic              prio_q, prio_d;
    logic              choose_q, choose_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
    logic              grant1, grant2;

    // prio_q = 0 prefers Src1, 1 prefers Src2; rst_n gates grants so none leak during reset.
    always_comb begin
        grant1 = rst_n & ~Hold & Valid1 & (~Valid2 | ~prio_q);
        grant2 = rst_n & ~Hold & Valid2 & (~Valid1 |  prio_q);
    end

    always_comb begin
        prio_d         = prio_q;
        choose_d       = choose_q;
        regwrite_d     = 1'b0;
        write_reg_d    = write_reg_q;
        write_data_d   = write_data_q;
        conflict_cnt_d = conflict_cnt_q;

        if (grant1) begin
            prio_d       = 1'b1;
            choose_d     = 1'b0;
            regwrite_d   = |Addr1;
            write_reg_d  = Addr1;
            write_data_d = Data1;
        end else if (grant2) begin
            prio_d       = 1'b0;
            choose_d     = 1'b1;
            regwrite_d   = |Addr2;
            write_reg_d  = Addr2;
            write_data_d = Data2;
        end

        // Contention is counted even while Hold blocks the port; saturate, never wrap.
        if (Valid1 && Valid2 && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q         <= 1'b0;
            choose_q       <= 1'b0;
            regwrite_q     <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            prio_q         <= prio_d;
            choose_q       <= choose_d;
            regwrite_q     <= regwrite_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign Ready1      = grant1;
    assign Ready2      = grant2;
    assign choose      = choose_q;
    assign RegWrite    = regwrite_q;
    assign WriteReg    = write_reg_q;
    assign WriteData   = write_data_q;
    assign ConflictCnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: the driver predicts grants/writes from the arbitration
// rules, a negedge monitor pops and compares. A CNT_W=4 instance shares stimulus for saturation.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Valid1 = 1'b0, Valid2 = 1'b0, Hold = 1'b0;
    logic [4:0]  Addr1 = '0, Addr2 = '0;
    logic [31:0] Data1 = '0, Data2 = '0;

    logic        Ready1, Ready2, choose, RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [15:0] ConflictCnt;

    logic        s_Ready1, s_Ready2, s_choose, s_RegWrite;
    logic [4:0]  s_WriteReg;
    logic [31:0] s_WriteData;
    logic [3:0]  s_ConflictCnt;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .Valid1(Valid1), .Addr1(Addr1), .Data1(Data1), .Ready1(Ready1),
        .Valid2(Valid2), .Addr2(Addr2), .Data2(Data2), .Ready2(Ready2),
        .Hold(Hold), .choose(choose), .RegWrite(RegWrite),
        .WriteReg(WriteReg), .WriteData(WriteData), .ConflictCnt(ConflictCnt)
    );

    wb_port_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .Valid1(Valid1), .Addr1(Addr1), .Data1(Data1), .Ready1(s_Ready1),
        .Valid2(Valid2), .Addr2(Addr2), .Data2(Data2), .Ready2(s_Ready2),
        .Hold(Hold), .choose(s_choose), .RegWrite(s_RegWrite),
        .WriteReg(s_WriteReg), .WriteData(s_WriteData), .ConflictCnt(s_ConflictCnt)
    );

    typedef struct {
        logic [1:0]  rdy;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } cyc_t;

    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ch;
    } wr_t;

    cyc_t cyc_q[$];
    wr_t  wr_q[$];

    int errors = 0;
    int checks = 0;
    int pref   = 1;      // source number currently preferred under contention
    int cnt16  = 0;
    int cnt4   = 0;
    bit mon_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request cycle, predict its outcome, then advance to just after the edge.
    // With rst_mid set, reset asserts after the negedge so this cycle's transfer is dropped.
    task automatic cycle(input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                         input bit v2, input logic [4:0] a2, input logic [31:0] d2,
                         input bit h, input bit rst_mid, output int g);
        cyc_t c;
        wr_t  w;
        Valid1 = v1; Addr1 = a1; Data1 = d1;
        Valid2 = v2; Addr2 = a2; Data2 = d2;
        Hold   = h;
        c.cnt16 = 16'(cnt16);
        c.cnt4  = 4'(cnt4);
        if (v1 && v2) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
        end
        g = 0;
        if (!h) begin
            if (v1 && v2) g = pref;
            else if (v1)  g = 1;
            else if (v2)  g = 2;
        end
        c.rdy = (g == 1) ? 2'b01 : (g == 2) ? 2'b10 : 2'b00;
        cyc_q.push_back(c);
        if (g != 0) begin
            w.addr = (g == 1) ? a1 : a2;
            w.data = (g == 1) ? d1 : d2;
            w.rw   = (w.addr != 5'd0);
            w.ch   = (g == 2);
            wr_q.push_back(w);
            pref = (g == 1) ? 2 : 1;
        end
        if (rst_mid) begin
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("rst_ready", {Ready2, Ready1}, 2'b00);
            check("rst_regwrite", RegWrite, 1'b0);
            check("rst_writereg", WriteReg, 5'd0);
            check("rst_writedata", WriteData, 32'd0);
            check("rst_choose", choose, 1'b0);
            check("rst_cnt", ConflictCnt, 16'd0);
            check("rst_cnt4", s_ConflictCnt, 4'd0);
            wr_q.delete();
            pref  = 1;
            cnt16 = 0;
            cnt4  = 0;
            @(posedge clk);
            #1;
            Valid1 = 1'b0; Valid2 = 1'b0; Hold = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        cyc_t c;
        wr_t  w;
        if (!rst_n) begin
            mon_prev = 1'b0;
        end else begin
            if (cyc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_cycle: got empty queue expected a record at %0t", $time);
            end else begin
                c = cyc_q.pop_front();
                check("ready", {Ready2, Ready1}, c.rdy);
                check("ready_sat", {s_Ready2, s_Ready1}, c.rdy);
                check("conflict_cnt", ConflictCnt, c.cnt16);
                check("conflict_cnt4", s_ConflictCnt, c.cnt4);
            end
            if (mon_prev) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_write: got empty queue expected a write at %0t", $time);
                end else begin
                    w = wr_q.pop_front();
                    check("regwrite", RegWrite, w.rw);
                    check("writereg", WriteReg, w.addr);
                    check("writedata", WriteData, w.data);
                    check("choose", choose, w.ch);
                    check("regwrite_sat", s_RegWrite, w.rw);
                    $display("write src%0d addr=%0h data=%08h regwrite=%0b cnt=%0d",
                             choose + 1, WriteReg, WriteData, RegWrite, ConflictCnt);
                end
            end else begin
                check("regwrite_idle", RegWrite, 1'b0);
                check("regwrite_idle_sat", s_RegWrite, 1'b0);
            end
            mon_prev = Ready1 | Ready2;
        end
    end

    initial begin : stimulus
        int g;
        bit p1, p2;
        logic [4:0]  ra1, ra2;
        logic [31:0] rd1, rd2;
        p1 = 0; p2 = 0; ra1 = '0; ra2 = '0; rd1 = '0; rd2 = '0;

        // Outputs and grants held at zero during reset, even with a request present.
        repeat (2) @(posedge clk);
        #1;
        Valid1 = 1'b1;
        #1;
        check("reset_ready1", Ready1, 1'b0);
        check("reset_regwrite", RegWrite, 1'b0);
        check("reset_writereg", WriteReg, 5'd0);
        check("reset_cnt", ConflictCnt, 16'd0);
        Valid1 = 1'b0;
        rst_n  = 1'b1;

        // Contention from reset: alternate Src1, Src2, Src1, Src2.
        repeat (4) cycle(1, 5'h07, 32'h7, 1, 5'h08, 32'h8, 0, 0, g);
        // Single source.
        cycle(1, 5'h07, 32'h11, 0, 5'h00, 32'h0, 0, 0, g);
        // Write to r0 from Src2.
        cycle(0, 5'h00, 32'h0, 1, 5'h00, 32'hDEAD_BEEF, 0, 0, g);
        // Hold with both valid, then release.
        repeat (3) cycle(1, 5'h03, 32'h33, 1, 5'h04, 32'h44, 1, 0, g);
        repeat (2) cycle(1, 5'h03, 32'h33, 1, 5'h04, 32'h44, 0, 0, g);
        // Saturation on the narrow counter.
        repeat (20) cycle(1, 5'h05, 32'h55, 1, 5'h06, 32'h66, 0, 0, g);
        // Reset mid-operation: Src2 write, then a Src1 transfer dropped by reset.
        cycle(0, 5'h00, 32'h0, 1, 5'h0A, 32'h9, 0, 0, g);
        cycle(1, 5'h0B, 32'hB, 0, 5'h00, 32'h0, 0, 1, g);
        cycle(1, 5'h0C, 32'hC, 0, 5'h00, 32'h0, 0, 0, g);
        cycle(0, 5'h00, 32'h0, 0, 5'h00, 32'h0, 0, 0, g);

        // Randomized traffic obeying the requester rules.
        for (int i = 0; i < 400; i++) begin
            if (!p1 && ($urandom_range(0, 99) < 60)) begin
                p1 = 1; ra1 = 5'($urandom_range(0, 31)); rd1 = $urandom;
            end
            if (!p2 && ($urandom_range(0, 99) < 60)) begin
                p2 = 1; ra2 = 5'($urandom_range(0, 31)); rd2 = $urandom;
            end
            cycle(p1, ra1, rd1, p2, ra2, rd2, ($urandom_range(0, 99) < 15), 0, g);
            if (g == 1) p1 = 0;
            if (g == 2) p2 = 0;
        end
        repeat (2) cycle(0, 5'h00, 32'h0, 0, 5'h00, 32'h0, 0, 0, g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the single register-file write port between two write-back requesters, source 1 and source 2. It grants one requester per cycle and registers the winning destination address and data. It drives the `choose` select of the 5-bit destination mux (0 = Src1, 1 = Src2) and the register-file `RegWrite` strobe. It sits between the execute/memory write-back sources and the register file, replacing the static select of the destination mux.

## Interface
- `ADDR_W`, default 5: register address width; must match the destination mux width.
- `DATA_W`, default 32: write data width.
- `CNT_W`, default 16: conflict counter width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `Valid1`  in  1  source 1 write request.
- `Addr1`  in  ADDR_W  source 1 destination register.
- `Data1`  in  DATA_W  source 1 write data.
- `Ready1`  out  1  source 1 granted this cycle (combinational).
- `Valid2`, `Addr2`, `Data2`, `Ready2`: same as above, for source 2.
- `Hold`  in  1  register-file port unavailable; blocks all grants.
- `choose`  out  1  registered select for the destination mux; 0 = Src1, 1 = Src2.
- `RegWrite`  out  1  registered write strobe, one cycle per accepted write.
- `WriteReg`  out  ADDR_W  registered destination address.
- `WriteData`  out  DATA_W  registered write data.
- `ConflictCnt`  out  CNT_W  saturating count of cycles in which both sources requested.

## Operation
- Internal priority bit `Prio`: 0 means Src1 is preferred, 1 means Src2 is preferred.
- Grant logic, evaluated every cycle while `Hold` = 0:
  - Only one source valid: that source is granted.
  - Both sources valid: the preferred source is granted.
  - Neither source valid: no grant.
- While `Hold` = 1: `Ready1` = `Ready2` = 0, and `Prio` is unchanged.
- A transfer occurs on `ValidN` & `ReadyN`. At most one transfer per cycle; `Ready1` and `Ready2` are never both 1.
- Priority update: after a Src1 transfer, `Prio` ← 1. After a Src2 transfer, `Prio` ← 0. With no transfer, `Prio` holds.
- Requester rules:
  - Hold `ValidN`, `AddrN` and `DataN` stable until the transfer.
  - `ValidN` may deassert only after the transfer.
  - `Ready` does not depend on the address or data values.
- Register-file outputs on a transfer:
  - `WriteReg` ← `AddrN`, `WriteData` ← `DataN`, `choose` ← N-1.
  - `RegWrite` ← 1 unless `AddrN` == 0. Register 0 is hardwired, so a write to it is accepted (Ready asserted) but `RegWrite` = 0.
- Register-file outputs with no transfer: `RegWrite` ← 0. `WriteReg`, `WriteData` and `choose` hold their last values.
- Both sources targeting the same address: no special handling. Writes land in grant order, so the later grant wins.
- `ConflictCnt`:
  - Increments on every cycle with `Valid1` & `Valid2`, including `Hold` cycles.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Reset, asynchronous, at any time:
  - `Prio` = 0; `RegWrite` = 0; `WriteReg` = 0; `WriteData` = 0; `choose` = 0; `ConflictCnt` = 0.
  - `Ready1` = `Ready2` = 0 while `rst_n` = 0.
  - A transfer in flight when reset asserts is dropped: no `RegWrite` follows reset release.

## Timing
- `Ready` is combinational in the request cycle. A requester never waits an extra cycle when uncontested.
- Latency: transfer in cycle t → `RegWrite`, `WriteReg`, `WriteData` and `choose` valid during cycle t+1.
- Write bandwidth is one write per cycle back-to-back.
- Under continuous contention the grants alternate strictly: Src1, Src2, Src1, …. The worst-case wait for either source is 1 cycle (plus `Hold` cycles).
- `Hold` takes effect in the same cycle it is asserted.
- The first grant after `rst_n` rises can occur in the first clock cycle.

## Test plan
- Single source: `Valid1`=1, `Addr1`=5'h07, `Data1`=32'h0000_0011, `Valid2`=0 → `Ready1`=1 that cycle. Next cycle: `RegWrite`=1, `WriteReg`=5'h07, `WriteData`=32'h11, `choose`=0.
- Contention from reset, both held valid for 4 cycles: Src1 {5'h07, 32'h7}, Src2 {5'h08, 32'h8} → grants alternate Src1, Src2, Src1, Src2. `choose` sequence one cycle later is 0, 1, 0, 1; `ConflictCnt`=4.
- Write to r0: `Valid2`=1, `Addr2`=5'h00, `Data2`=32'hDEAD_BEEF → `Ready2`=1. Next cycle `RegWrite`=0, `WriteReg`=5'h00, `choose`=1; `Prio` → 0.
- `Hold`: both valid, `Hold`=1 for 3 cycles, then 0 → no Ready and no `RegWrite` during the hold, `ConflictCnt`=3. The first grant after the hold goes to the source indicated by the unchanged `Prio`.
- Reset mid-operation: transfer Src2 {5'h0A, 32'h9}, then assert `rst_n`=0 before the next edge → all outputs 0 immediately. After release with `Valid1`=1, the first `RegWrite` carries Src1 and `choose`=0.
- Saturation with `CNT_W`=4: both valid for 20 cycles → `ConflictCnt` stops at 15.
